// File: rtl/uart_rx_framer_if.sv
// Serial-side and frame-side signals of the UART receive framer.
// master drives the line and the tick; slave is the framer.
interface uart_rx_framer_if;
  logic       baud_tick;
  logic       rx;
  logic [8:0] frame_out;
  logic       frame_valid;
  logic       frame_err;
  logic       busy;

  modport master (output baud_tick, rx, input frame_out, frame_valid, frame_err, busy);
  modport slave  (input baud_tick, rx, output frame_out, frame_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: start, 8 data bits LSB first, parity and stop bit.
// Parity is passed through unchecked as frame_out[8].
module uart_rx_framer #(
  parameter int OVERSAMPLE = 16
) (
  input logic             clk,
  input logic             rst,
  uart_rx_framer_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        r_state, w_next;
  logic          r_rx_meta, r_rx_s;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [8:0]    r_frame;
  logic          r_valid, r_err;
  logic          w_cnt_done, w_smp;

  // START waits half a bit to land mid-bit; later states wait a whole bit.
  always_comb begin
    w_cnt_done = 1'b1;
    case (r_state)
      START:              w_cnt_done = (r_tick == HALF);
      DATA, PARITY, STOP: w_cnt_done = (r_tick == FULL);
      default:            w_cnt_done = 1'b1;
    endcase
    w_smp = bus.baud_tick && w_cnt_done;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.baud_tick && !r_rx_s) w_next = START;
      START:     if (w_smp) w_next = r_rx_s ? IDLE : DATA;
      DATA:      if (w_smp && r_bit == 3'd7) w_next = PARITY;
      PARITY:    if (w_smp) w_next = STOP;
      STOP:      if (w_smp) w_next = r_rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (bus.baud_tick && r_rx_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_frame   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_valid   <= 1'b0;
      if (bus.baud_tick) r_tick <= w_cnt_done ? '0 : r_tick + 1'b1;
      if (r_state == IDLE) r_bit <= '0;
      if (r_state == DATA && w_smp) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
      if (r_state == PARITY && w_smp) r_par <= r_rx_s;
      if (r_state == STOP && w_smp) begin
        r_frame <= {r_par, r_shift};
        r_err   <= ~r_rx_s;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.frame_out   = r_frame;
  assign bus.frame_valid = r_valid;
  assign bus.frame_err   = r_err;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: clean frames, parity pass-through,
// false start, break, mid-frame reset, back-to-back and continuous tick.
module tb_uart_rx_framer;
  localparam int OS   = 16;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   tick_cont = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   vcnt = 0, busy_cyc = 0, cyc = 0;
  int   vtime[$];

  uart_rx_framer_if bus();
  uart_rx_framer #(.OVERSAMPLE(OS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      c = (c == TDIV - 1) ? 0 : c + 1;
      bus.baud_tick = tick_cont || (c == 0);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.frame_valid) begin
      vcnt++;
      vtime.push_back(cyc);
    end
    if (bus.busy) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!bus.baud_tick);
    end
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    wait_ticks(OS);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  initial begin
    int v0, b0, n0;
    logic [7:0] d;
    bus.rx = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_frame_out", 32'(bus.frame_out), 32'h000);
    chk("rst_valid", 32'(bus.frame_valid), 0);
    chk("rst_err", 32'(bus.frame_err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);

    v0 = vcnt;
    send(8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1);
    chk("a5_count", 32'(vcnt - v0), 1);
    chk("a5_frame", 32'(bus.frame_out), 32'h0A5);
    chk("a5_err", 32'(bus.frame_err), 0);
    chk("a5_perr", 32'(^bus.frame_out), 0);
    chk("a5_busy", 32'(bus.busy), 0);

    send(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1);
    chk("07p1_frame", 32'(bus.frame_out), 32'h107);
    chk("07p1_err", 32'(bus.frame_err), 0);
    chk("07p1_perr", 32'(^bus.frame_out), 0);
    send(8'h07, 1'b0, 1'b1);
    drive_bit(1'b1);
    chk("07p0_frame", 32'(bus.frame_out), 32'h007);
    chk("07p0_perr", 32'(^bus.frame_out), 1);

    v0 = vcnt;
    b0 = busy_cyc;
    bus.rx = 1'b0;
    wait_ticks(OS / 4);
    bus.rx = 1'b1;
    wait_ticks(OS);
    chk("fs_busy_pulsed", 32'(busy_cyc > b0), 1);
    chk("fs_no_valid", 32'(vcnt - v0), 0);
    chk("fs_idle", 32'(bus.busy), 0);
    chk("fs_frame_held", 32'(bus.frame_out), 32'h007);
    send(8'h3C, 1'b0, 1'b1);
    drive_bit(1'b1);
    chk("3c_frame", 32'(bus.frame_out), 32'h03C);

    v0 = vcnt;
    send(8'h55, 1'b0, 1'b0);
    wait_ticks(2 * OS);
    chk("brk_count", 32'(vcnt - v0), 1);
    chk("brk_err", 32'(bus.frame_err), 1);
    chk("brk_frame", 32'(bus.frame_out), 32'h055);
    chk("brk_wait_busy", 32'(bus.busy), 1);
    bus.rx = 1'b1;
    wait_ticks(OS);
    chk("brk_idle", 32'(bus.busy), 0);
    chk("brk_count_after", 32'(vcnt - v0), 1);

    v0 = vcnt;
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    bus.rx = d[3];
    wait_ticks(OS / 2);
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_frame", 32'(bus.frame_out), 32'h000);
    chk("mrst_err", 32'(bus.frame_err), 0);
    chk("mrst_valid", 32'(bus.frame_valid), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    wait_ticks(2 * OS);
    chk("mrst_no_valid", 32'(vcnt - v0), 0);
    send(8'h81, 1'b0, 1'b1);
    drive_bit(1'b1);
    chk("81_frame", 32'(bus.frame_out), 32'h081);

    v0 = vcnt;
    n0 = vtime.size();
    send(8'h12, 1'b0, 1'b1);
    chk("b2b_first", 32'(bus.frame_out), 32'h012);
    send(8'h34, 1'b1, 1'b1);
    drive_bit(1'b1);
    chk("b2b_count", 32'(vcnt - v0), 2);
    if (vtime.size() >= n0 + 2)
      chk("b2b_spacing", 32'(vtime[n0 + 1] - vtime[n0]), 32'(11 * OS * TDIV));
    else
      chk("b2b_spacing_missing", 32'(vtime.size() - n0), 2);
    chk("b2b_second", 32'(bus.frame_out), 32'h134);

    tick_cont = 1'b1;
    drive_bit(1'b1);
    v0 = vcnt;
    send(8'h96, 1'b0, 1'b1);
    drive_bit(1'b1);
    chk("cont_count", 32'(vcnt - v0), 1);
    chk("cont_frame", 32'(bus.frame_out), 32'h096);
    chk("cont_err", 32'(bus.frame_err), 0);
    tick_cont = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
